e_mdu: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core, the sequential counterpart of the combinational E-stage ALU.
- Executes mult/multu/div/divu/mthi/mtlo and owns the HI/LO registers.
- Exposes busy so the hazard unit can stall mfhi/mflo/mult-class instructions in D.
- Honours the CP0 exception/interrupt request so an instruction flushed in E never commits.

---
 rtl/e_mdu_pkg.sv | 30 +++
 rtl/e_mdu_if.sv | 16 +
 rtl/e_mdu_calc.sv | 56 +++++
 rtl/e_mdu.sv | 102 ++++++++++
 tb/tb_e_mdu.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU constants: operation encodings, FSM states and op-class helpers
// for the E-stage multiply/divide unit.
package e_mdu_pkg;

    localparam int MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mthi  = 4'd5,
        MDU_mtlo  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

    function automatic logic is_long_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_mult) || (op == MDU_multu) || is_div_op(op);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU bundle: forwarded operands and op code in, busy and HI/LO out.
interface e_mdu_if;

    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDUOp, start, req, input busy, HI, LO);
    modport slave  (input A, B, MDUOp, start, req, output busy, HI, LO);

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic: full 64-bit products and quotient/remainder,
// plus a write-enable that is low for a divide by zero.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_wr
);

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_bz;
    logic               w_ovf;
    logic signed [31:0] w_as;
    logic signed [31:0] w_bs;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_bu;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    assign w_bz  = (i_b == 32'd0);
    assign w_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Dividing the overflow case by 1 yields exactly LO=0x80000000, HI=0.
    assign w_as  = i_a;
    assign w_bs  = (w_bz || w_ovf) ? 32'sd1 : i_b;
    assign w_q_s = w_as / w_bs;
    assign w_r_s = w_as % w_bs;

    assign w_bu  = w_bz ? 32'd1 : i_b;
    assign w_q_u = i_a / w_bu;
    assign w_r_u = i_a % w_bu;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        o_wr = 1'b0;
        case (i_op)
            MDU_mult:  begin {o_hi, o_lo} = w_prod_s; o_wr = 1'b1; end
            MDU_multu: begin {o_hi, o_lo} = w_prod_u; o_wr = 1'b1; end
            MDU_div:   begin o_hi = w_r_s; o_lo = w_q_s; o_wr = !w_bz; end
            MDU_divu:  begin o_hi = w_r_u; o_lo = w_q_u; o_wr = !w_bz; end
            default:   begin o_wr = 1'b0; end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO; the result is computed
// at issue and held privately until the busy count expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi_n;
    logic [31:0]        r_lo_n;
    logic               r_wr_n;

    mdu_state_e         w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [31:0]        w_hi_nx;
    logic [31:0]        w_lo_nx;
    logic               w_accept;
    logic [31:0]        w_calc_hi;
    logic [31:0]        w_calc_lo;
    logic               w_calc_wr;

    e_mdu_calc u_calc (
        .i_a  (bus.A),
        .i_b  (bus.B),
        .i_op (bus.MDUOp),
        .o_hi (w_calc_hi),
        .o_lo (w_calc_lo),
        .o_wr (w_calc_wr)
    );

    assign w_accept = bus.start && !bus.req && (r_state == S_IDLE) && is_long_op(bus.MDUOp);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_RUN;
                    w_cnt_nx   = is_div_op(bus.MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (!bus.req && bus.MDUOp == MDU_mthi) begin
                    w_hi_nx = bus.A;
                end else if (!bus.req && bus.MDUOp == MDU_mtlo) begin
                    w_lo_nx = bus.A;
                end
            end
            S_RUN: begin
                w_cnt_nx = r_cnt - CNT_W'(1);
                // Commit on the last busy cycle; a divide by zero leaves HI/LO alone.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_IDLE;
                    if (r_wr_n) begin
                        w_hi_nx = r_hi_n;
                        w_lo_nx = r_lo_n;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hi_n <= w_calc_hi;
            r_lo_n <= w_calc_lo;
            r_wr_n <= w_calc_wr;
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a vector table of single operations plus hand
// sequences for start-while-busy and reset mid-operation.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        st;
        logic        rq;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.MDUOp = MDU_none;
        bus.start = 1'b0;
        bus.req   = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic st, input logic rq,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.MDUOp = op;
        bus.start = st;
        bus.req   = rq;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        int   n;
        logic stable;
        issue(t.op, t.st, t.rq, t.a, t.b);
        n = 0;
        stable = 1'b1;
        while (bus.busy === 1'b1 && n < 50) begin
            if (bus.HI !== exp_hi || bus.LO !== exp_lo) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(t.cyc));
        chk($sformatf("v%0d hilo_held_while_busy", idx), {31'd0, stable}, 32'd1);
        exp_hi = t.hi;
        exp_lo = t.lo;
        chk($sformatf("v%0d HI", idx), bus.HI, exp_hi);
        chk($sformatf("v%0d LO", idx), bus.LO, exp_lo);
    endtask

    initial begin
        int n;
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        vt[0]  = '{MDU_mult,  1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vt[1]  = '{MDU_multu, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
        vt[2]  = '{MDU_div,   1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[3]  = '{MDU_mthi,  1'b0, 1'b0, 32'h1234_5678, 32'd0,        0,  32'h1234_5678, 32'hFFFF_FFFD};
        vt[4]  = '{MDU_mtlo,  1'b0, 1'b0, 32'd0,         32'd0,        0,  32'h1234_5678, 32'd0};
        vt[5]  = '{MDU_divu,  1'b1, 1'b0, 32'd7,         32'd0,        10, 32'h1234_5678, 32'd0};
        vt[6]  = '{MDU_div,   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000};
        vt[7]  = '{MDU_mult,  1'b1, 1'b1, 32'd3,         32'd4,        0,  32'd0,         32'h8000_0000};
        vt[8]  = '{MDU_mtlo,  1'b0, 1'b1, 32'h0000_00AA, 32'd0,        0,  32'd0,         32'h8000_0000};
        vt[9]  = '{MDU_divu,  1'b1, 1'b0, 32'd100,       32'd7,        10, 32'd2,         32'd14};
        vt[10] = '{MDU_div,   1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD};
        vt[11] = '{MDU_none,  1'b1, 1'b0, 32'd5,         32'd6,        0,  32'd1,         32'hFFFF_FFFD};

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // Second start during a mult must be ignored, not queued.
        issue(MDU_mult, 1'b1, 1'b0, 32'd3, 32'd4);
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            if (n == 2) begin
                bus.MDUOp = MDU_divu;
                bus.start = 1'b1;
                bus.A     = 32'd100;
                bus.B     = 32'd7;
            end else begin
                drive_idle();
            end
            n++;
            @(negedge clk);
        end
        drive_idle();
        chk("stray busy_cycles", 32'(n), 32'd5);
        chk("stray HI", bus.HI, 32'd0);
        chk("stray LO", bus.LO, 32'd12);
        @(negedge clk);
        chk("stray no_requeue busy", {31'd0, bus.busy}, 32'd0);

        // Reset in the 4th busy cycle of a divide aborts it.
        issue(MDU_divu, 1'b1, 1'b0, 32'd100, 32'd7);
        n = 0;
        while (bus.busy === 1'b1 && n < 3) begin
            n++;
            @(negedge clk);
        end
        chk("abort reached cycle4", 32'(n), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort HI", bus.HI, 32'd0);
        chk("abort LO", bus.LO, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort late busy", {31'd0, bus.busy}, 32'd0);
        chk("abort late HI", bus.HI, 32'd0);
        chk("abort late LO", bus.LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
